// File: rtl/bayer_pkg.sv
// Shared encodings for the Bayer 2x2 binning block: CFA phases, output
// modes and the fixed-point luma weights (sum to 256).
package bayer_pkg;

  // 2x2 CFA layouts, listed TL,TR,BL,BR
  localparam int PHASE_RGGB = 0;
  localparam int PHASE_GRBG = 1;
  localparam int PHASE_GBRG = 2;
  localparam int PHASE_BGGR = 3;

  typedef enum logic [1:0] {
    MODE_AVG  = 2'd0,
    MODE_LUMA = 2'd1,
    MODE_RGB  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // Luma weights in 1/256 units; 77 + 150 + 29 = 256 keeps full scale in range
  localparam logic [7:0] LUMA_COEF_R = 8'd77;
  localparam logic [7:0] LUMA_COEF_G = 8'd150;
  localparam logic [7:0] LUMA_COEF_B = 8'd29;

endpackage

// File: rtl/bayer_phase_mux.sv
// Routes the four 2x2 block positions onto R/G1/G2/B according to the
// sensor's CFA phase. Purely combinational; the phase is fixed at elaboration.
module bayer_phase_mux
  import bayer_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int BAYER_PHASE = 0
) (
  input  logic [DATA_W-1:0] tl,
  input  logic [DATA_W-1:0] tr,
  input  logic [DATA_W-1:0] bl,
  input  logic [DATA_W-1:0] br,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] g1,
  output logic [DATA_W-1:0] g2,
  output logic [DATA_W-1:0] b
);

  generate
    if (BAYER_PHASE == PHASE_GRBG) begin : g_grbg
      // G R / B G
      assign g1 = tl;
      assign r  = tr;
      assign b  = bl;
      assign g2 = br;
    end else if (BAYER_PHASE == PHASE_GBRG) begin : g_gbrg
      // G B / R G
      assign g1 = tl;
      assign b  = tr;
      assign r  = bl;
      assign g2 = br;
    end else if (BAYER_PHASE == PHASE_BGGR) begin : g_bggr
      // B G / G R
      assign b  = tl;
      assign g1 = tr;
      assign g2 = bl;
      assign r  = br;
    end else begin : g_rggb
      // R G / G B (also the fallback for out-of-range phase values)
      assign r  = tl;
      assign g1 = tr;
      assign g2 = bl;
      assign b  = br;
    end
  endgenerate

endmodule

// File: rtl/bayer_binning.sv
// 2x2 Bayer binning: pairs the even-column taps with the following odd-column
// taps to form one block per 2x2 cell, then produces average, luma or RGB
// results through a three-register pipeline (one block per cycle).
module bayer_binning
  import bayer_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int COORD_W     = 11,
  parameter int BAYER_PHASE = 0
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [DATA_W-1:0]  iCurrRow,
  input  logic [DATA_W-1:0]  iPrevRow,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic [1:0]         iMode,
  output logic [DATA_W-1:0]  oGray,
  output logic [DATA_W-1:0]  oR,
  output logic [DATA_W-1:0]  oG,
  output logic [DATA_W-1:0]  oB,
  output logic [COORD_W-2:0] oX,
  output logic [COORD_W-2:0] oY,
  output logic               oDVAL,
  output logic               oSOF
);

  // Input qualification
  logic even_cap;
  logic accept;
  logic frame_start;

  // Left-column capture and frame mode
  logic [DATA_W-1:0] left_curr_reg;
  logic [DATA_W-1:0] left_prev_reg;
  logic              have_left_reg;
  mode_t             mode_reg;

  // Channel extraction
  logic [DATA_W-1:0] mux_r, mux_g1, mux_g2, mux_b;

  // Stage 1: extracted channels
  logic               s1_valid_reg;
  logic [DATA_W-1:0]  s1_r_reg, s1_g1_reg, s1_g2_reg, s1_b_reg;
  mode_t              s1_mode_reg;
  logic [COORD_W-2:0] s1_x_reg, s1_y_reg;
  logic               s1_sof_reg;

  // Stage 2: green merged, block average
  logic               s2_valid_reg;
  logic [DATA_W-1:0]  s2_r_reg, s2_g_reg, s2_b_reg, s2_avg_reg;
  mode_t              s2_mode_reg;
  logic [COORD_W-2:0] s2_x_reg, s2_y_reg;
  logic               s2_sof_reg;

  // Arithmetic
  logic [DATA_W+1:0] sum4;
  logic [DATA_W:0]   g_sum;
  logic [DATA_W+7:0] luma_acc;
  logic [DATA_W-1:0] gray_sel;
  logic [10:0]       unused_bits;

  assign even_cap    = iDVAL & ~iX_Cont[0];
  assign accept      = iDVAL & iX_Cont[0] & iY_Cont[0] & have_left_reg;
  assign frame_start = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);

  bayer_phase_mux #(
    .DATA_W      (DATA_W),
    .BAYER_PHASE (BAYER_PHASE)
  ) u_phase_mux (
    .tl (left_prev_reg),
    .tr (iPrevRow),
    .bl (left_curr_reg),
    .br (iCurrRow),
    .r  (mux_r),
    .g1 (mux_g1),
    .g2 (mux_g2),
    .b  (mux_b)
  );

  // Left column capture, pairing flag and per-frame mode latch
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      left_curr_reg <= '0;
      left_prev_reg <= '0;
      have_left_reg <= 1'b0;
      mode_reg      <= MODE_AVG;
    end else begin
      if (even_cap) begin
        left_curr_reg <= iCurrRow;
        left_prev_reg <= iPrevRow;
      end
      // even and odd columns are exclusive, so set and clear never collide
      if (accept) begin
        have_left_reg <= 1'b0;
      end else if (even_cap) begin
        have_left_reg <= 1'b1;
      end
      if (frame_start) begin
        mode_reg <= mode_t'(iMode);
      end
    end
  end

  // Stage 1: register the routed channels with the mode in force at acceptance
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_valid_reg <= 1'b0;
      s1_r_reg     <= '0;
      s1_g1_reg    <= '0;
      s1_g2_reg    <= '0;
      s1_b_reg     <= '0;
      s1_mode_reg  <= MODE_AVG;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
      s1_sof_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_r_reg    <= mux_r;
        s1_g1_reg   <= mux_g1;
        s1_g2_reg   <= mux_g2;
        s1_b_reg    <= mux_b;
        s1_mode_reg <= mode_reg;
        s1_x_reg    <= iX_Cont[COORD_W-1:1];
        s1_y_reg    <= iY_Cont[COORD_W-1:1];
        s1_sof_reg  <= (iX_Cont[COORD_W-1:1] == '0) && (iY_Cont[COORD_W-1:1] == '0);
      end
    end
  end

  // Full-width sums so nothing overflows before the truncating shift
  always_comb begin
    sum4  = {2'b00, s1_r_reg} + {2'b00, s1_g1_reg} + {2'b00, s1_g2_reg} + {2'b00, s1_b_reg};
    g_sum = {1'b0, s1_g1_reg} + {1'b0, s1_g2_reg};
  end

  // Stage 2: merged green and block average
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s2_valid_reg <= 1'b0;
      s2_r_reg     <= '0;
      s2_g_reg     <= '0;
      s2_b_reg     <= '0;
      s2_avg_reg   <= '0;
      s2_mode_reg  <= MODE_AVG;
      s2_x_reg     <= '0;
      s2_y_reg     <= '0;
      s2_sof_reg   <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_r_reg    <= s1_r_reg;
        s2_g_reg    <= g_sum[DATA_W:1];
        s2_b_reg    <= s1_b_reg;
        s2_avg_reg  <= sum4[DATA_W+1:2];
        s2_mode_reg <= s1_mode_reg;
        s2_x_reg    <= s1_x_reg;
        s2_y_reg    <= s1_y_reg;
        s2_sof_reg  <= s1_sof_reg;
      end
    end
  end

  // Luma weights total 256, so the top DATA_W bits never exceed full scale
  always_comb begin
    luma_acc = {{DATA_W{1'b0}}, LUMA_COEF_R} * {8'd0, s2_r_reg}
             + {{DATA_W{1'b0}}, LUMA_COEF_G} * {8'd0, s2_g_reg}
             + {{DATA_W{1'b0}}, LUMA_COEF_B} * {8'd0, s2_b_reg};
    // reserved mode falls back to the average, as does RGB
    gray_sel = (s2_mode_reg == MODE_LUMA) ? luma_acc[DATA_W+7:8] : s2_avg_reg;
  end

  // Fractional bits discarded by the shifts
  assign unused_bits = {sum4[1:0], g_sum[0], luma_acc[7:0]};

  // Stage 3: output registers, held between valid pulses
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oGray <= '0;
      oR    <= '0;
      oG    <= '0;
      oB    <= '0;
      oX    <= '0;
      oY    <= '0;
      oSOF  <= 1'b0;
    end else begin
      oDVAL <= s2_valid_reg;
      if (s2_valid_reg) begin
        oGray <= gray_sel;
        oR    <= s2_r_reg;
        oG    <= s2_g_reg;
        oB    <= s2_b_reg;
        oX    <= s2_x_reg;
        oY    <= s2_y_reg;
        oSOF  <= s2_sof_reg;
      end
    end
  end

endmodule

// File: tb/tb_bayer_binning.sv
// Scoreboard bench for bayer_binning: an RGGB and a BGGR instance share the
// data/coordinate inputs with separate iDVAL strobes; directed blocks push
// hand-computed results, per-instance monitors pop and compare on oDVAL.
module tb_bayer_binning;

  logic        clk;
  logic        rst;
  logic [11:0] curr;
  logic [11:0] prev;
  logic [10:0] xc;
  logic [10:0] yc;
  logic [1:0]  mode;
  logic        dval0;
  logic        dval1;

  logic [11:0] gray0, r0, g0, b0;
  logic [9:0]  ox0, oy0;
  logic        odv0, sof0;
  logic [11:0] gray1, r1, g1, b1;
  logic [9:0]  ox1, oy1;
  logic        odv1, sof1;

  typedef struct {
    int gray;
    int r;
    int g;
    int b;
    int x;
    int y;
    int sof;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  bayer_binning #(.DATA_W(12), .COORD_W(11), .BAYER_PHASE(0)) u_rggb (
    .iCLK(clk), .iRST(rst), .iCurrRow(curr), .iPrevRow(prev), .iDVAL(dval0),
    .iX_Cont(xc), .iY_Cont(yc), .iMode(mode),
    .oGray(gray0), .oR(r0), .oG(g0), .oB(b0), .oX(ox0), .oY(oy0),
    .oDVAL(odv0), .oSOF(sof0)
  );

  bayer_binning #(.DATA_W(12), .COORD_W(11), .BAYER_PHASE(3)) u_bggr (
    .iCLK(clk), .iRST(rst), .iCurrRow(curr), .iPrevRow(prev), .iDVAL(dval1),
    .iX_Cont(xc), .iY_Cont(yc), .iMode(mode),
    .oGray(gray1), .oR(r1), .oG(g1), .oB(b1), .oX(ox1), .oY(oy1),
    .oDVAL(odv1), .oSOF(sof1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One input sample to instance d; the other instance sees iDVAL=0
  task automatic drive(input int d, input int x, input int y, input int c, input int p, input int m);
    @(negedge clk);
    xc    = 11'(x);
    yc    = 11'(y);
    curr  = 12'(c);
    prev  = 12'(p);
    mode  = 2'(m);
    dval0 = (d == 0);
    dval1 = (d == 1);
    last_cyc = cyc;
    @(posedge clk);
    #1;
    dval0 = 1'b0;
    dval1 = 1'b0;
  endtask

  task automatic expect_blk(input int d, input int eg, input int er, input int egg, input int eb,
                            input int bx, input int by);
    exp_t e;
    e.gray = eg; e.r = er; e.g = egg; e.b = eb;
    e.x = bx; e.y = by; e.sof = (bx == 0 && by == 0) ? 1 : 0;
    e.cyc = last_cyc + 3;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Full 2x2 block at block coordinate (bx,by) plus its expected result
  task automatic block(input int d, input int bx, input int by,
                       input int tl, input int tr, input int bl, input int br, input int m,
                       input int eg, input int er, input int egg, input int eb);
    drive(d, 2 * bx, 2 * by + 1, bl, tl, m);
    drive(d, 2 * bx + 1, 2 * by + 1, br, tr, m);
    expect_blk(d, eg, er, egg, eb, bx, by);
  endtask

  // Frame-start sample that latches the mode
  task automatic frame(input int d, input int m);
    drive(d, 0, 0, 0, 0, m);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic mon(input int d, input logic [11:0] og, input logic [11:0] orr, input logic [11:0] ogg,
                     input logic [11:0] ob, input logic [9:0] ox, input logic [9:0] oy, input logic os);
    exp_t e;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL dut%0d_unexpected_out actual gray=%0d x=%0d y=%0d required no output",
               d, og, ox, oy);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (int'(og) != e.gray || int'(orr) != e.r || int'(ogg) != e.g || int'(ob) != e.b ||
        int'(ox) != e.x || int'(oy) != e.y || int'(os) != e.sof) begin
      errors++;
      $display("FAIL dut%0d_block actual gray=%0d r=%0d g=%0d b=%0d x=%0d y=%0d sof=%0d required gray=%0d r=%0d g=%0d b=%0d x=%0d y=%0d sof=%0d",
               d, og, orr, ogg, ob, ox, oy, os, e.gray, e.r, e.g, e.b, e.x, e.y, e.sof);
    end else begin
      $display("dut%0d block x=%0d y=%0d gray=%0d r=%0d g=%0d b=%0d sof=%0d ok",
               d, ox, oy, og, orr, ogg, ob, os);
    end
    checks++;
    if (cyc != e.cyc) begin
      errors++;
      $display("FAIL dut%0d_latency actual cycle=%0d required cycle=%0d", d, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && odv0) mon(0, gray0, r0, g0, b0, ox0, oy0, sof0);
  end

  always @(negedge clk) begin
    if (!rst && odv1) mon(1, gray1, r1, g1, b1, ox1, oy1, sof1);
  end

  initial begin
    rst = 1'b1; curr = '0; prev = '0; xc = '0; yc = '0; mode = '0;
    dval0 = 1'b0; dval1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_odval0", 32'(odv0), 0);
    check("reset_odval1", 32'(odv1), 0);
    check("reset_gray0", 32'(gray0), 0);
    check("reset_sof0", 32'(sof0), 0);
    rst = 1'b0;

    // RGGB average, first block of the frame
    frame(0, 0);
    block(0, 0, 0, 100, 200, 300, 400, 0, 250, 100, 250, 400);

    // LUMA: red only, then full scale
    frame(0, 1);
    block(0, 1, 0, 1000, 0, 0, 0, 1, 300, 1000, 0, 0);
    block(0, 2, 0, 4095, 4095, 4095, 4095, 1, 4095, 4095, 4095, 4095);

    // Mode change mid-frame stays AVG, takes effect at the next frame
    frame(0, 0);
    block(0, 0, 1, 8, 16, 24, 32, 1, 20, 8, 20, 32);
    frame(0, 1);
    block(0, 0, 0, 8, 16, 24, 32, 1, 17, 8, 20, 32);

    // RGB mode and reserved mode (gray is the average in both)
    frame(0, 2);
    block(0, 3, 0, 10, 20, 30, 40, 2, 25, 10, 25, 40);
    frame(0, 3);
    block(0, 0, 0, 4000, 0, 0, 0, 3, 1000, 4000, 0, 0);

    // Even sample, three idle cycles, then the odd sample
    drive(0, 4, 1, 48, 40, 3);
    repeat (3) @(posedge clk);
    drive(0, 5, 1, 52, 44, 3);
    expect_blk(0, 46, 40, 46, 52, 2, 0);

    // No block on an even row, nor on an odd column without a fresh left capture
    drive(0, 0, 2, 500, 500, 0);
    drive(0, 1, 2, 500, 500, 0);
    block(0, 3, 1, 4, 8, 12, 16, 0, 10, 4, 10, 16);
    drive(0, 7, 3, 900, 900, 0);

    // Block in flight at reset is discarded; everything reads 0 during reset
    frame(0, 1);
    drive(0, 10, 11, 100, 100, 1);
    drive(0, 11, 11, 100, 100, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_odval", 32'(odv0), 0);
    check("rst_gray", 32'(gray0), 0);
    check("rst_r", 32'(r0), 0);
    check("rst_g", 32'(g0), 0);
    check("rst_b", 32'(b0), 0);
    check("rst_x", 32'(ox0), 0);
    check("rst_y", 32'(oy0), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Reset between the even capture and the odd sample: no output
    drive(0, 4, 1, 60, 60, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 5, 1, 60, 60, 0);
    repeat (5) @(posedge clk);

    // Mode returned to AVG by reset (LUMA would give 1203)
    block(0, 0, 0, 4000, 0, 0, 0, 1, 1000, 4000, 0, 0);

    // BGGR instance: RGB mode and LUMA mode
    frame(1, 2);
    block(1, 0, 0, 10, 20, 30, 40, 2, 25, 40, 25, 10);
    frame(1, 1);
    block(1, 1, 0, 0, 0, 0, 1000, 1, 300, 1000, 0, 0);

    // Drain with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    check("drain_q0", 32'(q0.size()), 0);
    check("drain_q1", 32'(q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
